// File: rtl/vga_bitstream_pkg.sv
// Shared types and sizing constants for the VGA bitstream capture stage.
package vga_bitstream_pkg;

    localparam int H_ACTIVE_DEF = 512;
    localparam int V_ACTIVE_DEF = 450;

    localparam int COL_W  = 9;
    localparam int ROW_W  = 9;
    localparam int ADDR_W = 18;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CAPTURE,
        ST_FROZEN
    } state_t;

endpackage

// File: rtl/vga_bitstream_bitmap_ram.sv
// Simple dual-port single-bit bitmap: synchronous write, registered read,
// read-before-write on an address collision. Contents are never cleared.
module vga_bitstream_bitmap_ram
    import vga_bitstream_pkg::*;
(
    input  logic              clk_i,
    input  logic              wrEn_i,
    input  logic [ADDR_W-1:0] wrAddr_i,
    input  logic              wrData_i,
    input  logic [ADDR_W-1:0] rdAddr_i,
    output logic              rdData_o
);

    logic mem [0:(1<<ADDR_W)-1];

    // Read samples the pre-write contents, so a same-cycle collision returns old data.
    always_ff @(posedge clk_i) begin
        if (wrEn_i) begin
            mem[wrAddr_i] <= wrData_i;
        end
        rdData_o <= mem[rdAddr_i];
    end

endmodule

// File: rtl/vga_bitstream_capture.sv
// Packs a valid/ready serial bitstream into a 1-bit bitmap and reads it back for the VGA raster.
// Optional rolling display (oldest row on top) is enabled by defining VGA_BITSTREAM_SCROLL_EN.
module vga_bitstream_capture
    import vga_bitstream_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF
)
(
    input  logic             iVGA_CLK,
    input  logic             iRST,
    input  logic [9:0]       iVGA_X,
    input  logic [9:0]       iVGA_Y,
    input  logic             iStart,
    input  logic             iStop,
    input  logic             iOneShot,
    input  logic             iValid,
    input  logic             iBit,
    output logic             oReady,
    output logic             oBit,
    output logic             oDone,
    output logic [ROW_W-1:0] oRow
);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(H_ACTIVE - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(V_ACTIVE - 1);

    state_t           state_q;
    logic [COL_W-1:0] col_q;
    logic [ROW_W-1:0] row_q;
    logic             oneShot_q;
    logic             done_q;
    logic             ready_q;
    logic             inWin_q;

    logic             accept_d;
    logic             inWin_d;
    logic [ROW_W-1:0] dispRow_d;
    logic             ramBit;

    assign accept_d = iValid & ready_q;
    assign inWin_d  = (iVGA_X < 10'(H_ACTIVE)) && (iVGA_Y < 10'(V_ACTIVE));

`ifdef VGA_BITSTREAM_SCROLL_EN
    // Row just after the write row lands on screen line 0, so the newest row sits at the bottom.
    logic [9:0] rowSum_d;
    assign rowSum_d  = {1'b0, row_q} + 10'd1 + iVGA_Y;
    assign dispRow_d = (rowSum_d >= 10'(V_ACTIVE)) ? ROW_W'(rowSum_d - 10'(V_ACTIVE))
                                                   : rowSum_d[ROW_W-1:0];
`else
    assign dispRow_d = iVGA_Y[ROW_W-1:0];
`endif

    always_ff @(posedge iVGA_CLK or posedge iRST) begin
        if (iRST) begin
            state_q   <= ST_IDLE;
            col_q     <= '0;
            row_q     <= '0;
            oneShot_q <= 1'b0;
            done_q    <= 1'b0;
            ready_q   <= 1'b0;
            inWin_q   <= 1'b0;
        end else begin
            inWin_q <= inWin_d;
            if (iStart) begin
                state_q   <= ST_CAPTURE;
                col_q     <= '0;
                row_q     <= '0;
                oneShot_q <= iOneShot;
                done_q    <= 1'b0;
                ready_q   <= 1'b1;
            end else begin
                if (accept_d) begin
                    if (col_q == COL_LAST) begin
                        col_q <= '0;
                        if (row_q == ROW_LAST) begin
                            // One-shot freezes on the last row; continuous wraps to the top.
                            if (oneShot_q) begin
                                state_q <= ST_FROZEN;
                                ready_q <= 1'b0;
                                done_q  <= 1'b1;
                            end else begin
                                row_q <= '0;
                            end
                        end else begin
                            row_q <= row_q + 1'b1;
                        end
                    end else begin
                        col_q <= col_q + 1'b1;
                    end
                end
                if (iStop && (state_q == ST_CAPTURE)) begin
                    state_q <= ST_FROZEN;
                    ready_q <= 1'b0;
                end
            end
        end
    end

    vga_bitstream_bitmap_ram uRam (
        .clk_i    (iVGA_CLK),
        .wrEn_i   (accept_d),
        .wrAddr_i ({row_q, col_q}),
        .wrData_i (iBit),
        .rdAddr_i ({dispRow_d, iVGA_X[COL_W-1:0]}),
        .rdData_o (ramBit)
    );

    assign oReady = ready_q;
    assign oDone  = done_q;
    assign oRow   = row_q;
    assign oBit   = ramBit & inWin_q;

endmodule

// File: tb/tb_vga_bitstream_capture.sv
// Self-checking bench for vga_bitstream_capture on a reduced 16 x 8 bitmap, with a
// count-based reference model; follows VGA_BITSTREAM_SCROLL_EN for the display mapping.
module tb_vga_bitstream_capture;

    localparam int H     = 16;
    localparam int V     = 8;
    localparam int CELLS = H * V;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] x, y;
    logic       start, stop, oneShot, valid, bitIn;
    logic       ready, bitOut, done;
    logic [8:0] row;

    int errors = 0;
    int checks = 0;

    // Reference model: the bitmap plus the number of bits accepted since the last start.
    bit refMem [V][H];
    bit known  [V][H];
    bit mReady, mDone, mOneShot;
    int mCount;

    typedef struct {
        bit       start, stop, os, valid;
        bit       expReady, expDone;
        int       expRow;
    } ctrlVec_t;

    typedef struct {
        int xi, yi;
        bit inWin;
    } winVec_t;

    ctrlVec_t ctrlVec [11];
    winVec_t  winVec  [7];

    always #5 clk = ~clk;

    vga_bitstream_capture #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (
        .iVGA_CLK (clk),
        .iRST     (rst),
        .iVGA_X   (x),
        .iVGA_Y   (y),
        .iStart   (start),
        .iStop    (stop),
        .iOneShot (oneShot),
        .iValid   (valid),
        .iBit     (bitIn),
        .oReady   (ready),
        .oBit     (bitOut),
        .oDone    (done),
        .oRow     (row)
    );

    function automatic int modelRow();
        if (mDone) return V - 1;
        return (mCount / H) % V;
    endfunction

    function automatic int dispRowOf(int yy);
`ifdef VGA_BITSTREAM_SCROLL_EN
        return (modelRow() + 1 + yy) % V;
`else
        return yy;
`endif
    endfunction

    function automatic int yForRow(int r);
`ifdef VGA_BITSTREAM_SCROLL_EN
        return (r - modelRow() - 1 + 2 * V) % V;
`else
        return r;
`endif
    endfunction

    function automatic int randX();
        return $urandom_range(H + 2, 0);
    endfunction

    function automatic int randY();
        return $urandom_range(V + 1, 0);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Drives one cycle, advances the model, then compares all outputs after the edge.
    task automatic applyStimulus(input int xi, input int yi, input bit v, input bit b,
                                 input bit s, input bit st, input bit os);
        bit expBit;
        bit expKnown;
        int dr, r, c;
        x = 10'(xi); y = 10'(yi); valid = v; bitIn = b;
        start = s; stop = st; oneShot = os;
        expBit = 1'b0;
        expKnown = 1'b1;
        if (xi < H && yi < V) begin
            dr = dispRowOf(yi);
            expKnown = known[dr][xi];
            expBit = refMem[dr][xi];
        end
        if (v && mReady) begin
            r = modelRow();
            c = mCount % H;
            refMem[r][c] = b;
            known[r][c] = 1'b1;
            mCount++;
            if (mOneShot && mCount == CELLS) begin
                mReady = 1'b0;
                mDone = 1'b1;
            end
        end
        if (s) begin
            mCount = 0;
            mDone = 1'b0;
            mReady = 1'b1;
            mOneShot = os;
        end else if (st) begin
            mReady = 1'b0;
        end
        @(posedge clk);
        #1;
        checkOutput("ready", ready, mReady);
        checkOutput("done", done, mDone);
        checkOutput("row", row, modelRow());
        if (expKnown) checkOutput("pixel", bitOut, expBit);
    endtask

    task automatic doReset();
        rst = 1'b1;
        #2;
        checkOutput("reset_ready", ready, 0);
        checkOutput("reset_bit", bitOut, 0);
        checkOutput("reset_done", done, 0);
        checkOutput("reset_row", row, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        mReady = 1'b0;
        mDone = 1'b0;
        mCount = 0;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int acc, budget;
        bit lastBit, old, v, b, expB;
        int r, c;

        ctrlVec[0]  = '{start:0, stop:1, os:0, valid:0, expReady:0, expDone:0, expRow:0};
        ctrlVec[1]  = '{start:0, stop:0, os:0, valid:1, expReady:0, expDone:0, expRow:0};
        ctrlVec[2]  = '{start:1, stop:0, os:0, valid:0, expReady:1, expDone:0, expRow:0};
        ctrlVec[3]  = '{start:0, stop:0, os:0, valid:1, expReady:1, expDone:0, expRow:0};
        ctrlVec[4]  = '{start:0, stop:0, os:0, valid:1, expReady:1, expDone:0, expRow:0};
        ctrlVec[5]  = '{start:1, stop:1, os:0, valid:0, expReady:1, expDone:0, expRow:0};
        ctrlVec[6]  = '{start:0, stop:0, os:0, valid:1, expReady:1, expDone:0, expRow:0};
        ctrlVec[7]  = '{start:0, stop:1, os:0, valid:0, expReady:0, expDone:0, expRow:0};
        ctrlVec[8]  = '{start:0, stop:0, os:0, valid:1, expReady:0, expDone:0, expRow:0};
        ctrlVec[9]  = '{start:1, stop:0, os:1, valid:0, expReady:1, expDone:0, expRow:0};
        ctrlVec[10] = '{start:0, stop:0, os:0, valid:1, expReady:1, expDone:0, expRow:0};

        winVec[0] = '{xi:0,     yi:0,    inWin:1};
        winVec[1] = '{xi:H - 1, yi:V - 1, inWin:1};
        winVec[2] = '{xi:H,     yi:0,    inWin:0};
        winVec[3] = '{xi:0,     yi:V,    inWin:0};
        winVec[4] = '{xi:512,   yi:0,    inWin:0};
        winVec[5] = '{xi:0,     yi:450,  inWin:0};
        winVec[6] = '{xi:1023,  yi:1023, inWin:0};

        x = '0; y = '0; start = 0; stop = 0; oneShot = 0; valid = 0; bitIn = 0;
        mReady = 0; mDone = 0; mOneShot = 0; mCount = 0;
        rst = 1'b0;
        #1;
        doReset();

        // Control table: stop ignored in IDLE, start wins over stop, ready follows state.
        foreach (ctrlVec[i]) begin
            applyStimulus($urandom_range(H - 1, 0), $urandom_range(V - 1, 0), ctrlVec[i].valid,
                          1'($urandom % 2), ctrlVec[i].start, ctrlVec[i].stop, ctrlVec[i].os);
            checkOutput("ctrl_ready", ready, ctrlVec[i].expReady);
            checkOutput("ctrl_done", done, ctrlVec[i].expDone);
            checkOutput("ctrl_row", row, ctrlVec[i].expRow);
        end

        // Single bit: 1 then 0 land at columns 0 and 1 of row 0.
        applyStimulus(0, 0, 0, 0, 1, 0, 1);
        applyStimulus(0, 0, 1, 1, 0, 0, 0);
        applyStimulus(0, 0, 1, 0, 0, 0, 0);
        checkOutput("single_row", row, 0);
        applyStimulus(0, yForRow(0), 0, 0, 0, 0, 0);
        checkOutput("single_bit_x0", bitOut, 1);
        applyStimulus(1, yForRow(0), 0, 0, 0, 0, 0);
        checkOutput("single_bit_x1", bitOut, 0);

        // Continuous wrap: CELLS+1 accepts overwrite cell (0,0) with the last bit.
        applyStimulus(randX(), randY(), 0, 0, 1, 0, 0);
        acc = 0;
        budget = 0;
        lastBit = 0;
        while (acc < CELLS + 1 && budget < 10 * CELLS) begin
            v = ($urandom % 4) != 0;
            b = 1'($urandom % 2);
            if (v) begin
                acc++;
                lastBit = b;
            end
            applyStimulus(randX(), randY(), v, b, 0, 0, 0);
            budget++;
        end
        checkOutput("wrap_accepts", acc, CELLS + 1);
        checkOutput("wrap_row", row, 0);
        applyStimulus(0, yForRow(0), 0, 0, 0, 0, 0);
        checkOutput("wrap_mem00", bitOut, lastBit);

        // Advance to write row 5 and probe the display mapping.
        for (int i = 0; i < 5 * H - 1; i++) applyStimulus(randX(), randY(), 1, 1'($urandom % 2), 0, 0, 0);
        checkOutput("scroll_row", row, 5);
`ifdef VGA_BITSTREAM_SCROLL_EN
        expB = refMem[6][3];
        applyStimulus(3, 0, 0, 0, 0, 0, 0);
        checkOutput("scroll_y0_row6", bitOut, expB);
        expB = refMem[0][4];
        applyStimulus(4, V - 6, 0, 0, 0, 0, 0);
        checkOutput("scroll_bottom_row0", bitOut, expB);
`else
        expB = refMem[3][3];
        applyStimulus(3, 3, 0, 0, 0, 0, 0);
        checkOutput("fixed_y3_row3", bitOut, expB);
        expB = refMem[V - 1][4];
        applyStimulus(4, V - 1, 0, 0, 0, 0, 0);
        checkOutput("fixed_last_row", bitOut, expB);
`endif

        // Read/write collision returns old data, new data the cycle after.
        r = modelRow();
        c = mCount % H;
        old = refMem[r][c];
        applyStimulus(c, yForRow(r), 1, !old, 0, 0, 0);
        checkOutput("collision_old", bitOut, old);
        applyStimulus(c, yForRow(r), 0, 0, 0, 0, 0);
        checkOutput("collision_new", bitOut, !old);

        // Window table: outside the active area the output is forced low.
        foreach (winVec[i]) begin
            expB = winVec[i].inWin ? refMem[dispRowOf(winVec[i].yi)][winVec[i].xi] : 1'b0;
            applyStimulus(winVec[i].xi, winVec[i].yi, 0, 0, 0, 0, 0);
            checkOutput("window", bitOut, expB);
        end

        // One-shot fill, then the next valid bit must be ignored.
        applyStimulus(randX(), randY(), 0, 0, 1, 0, 1);
        budget = 0;
        while (!mDone && budget < 10 * CELLS) begin
            applyStimulus(randX(), randY(), ($urandom % 4) != 0, 1'($urandom % 2), 0, 0, 0);
            budget++;
        end
        checkOutput("oneshot_done", done, 1);
        checkOutput("oneshot_ready", ready, 0);
        checkOutput("oneshot_row", row, V - 1);
        old = refMem[V - 1][0];
        applyStimulus(0, 0, 1, !old, 0, 0, 0);
        applyStimulus(0, yForRow(V - 1), 0, 0, 0, 0, 0);
        checkOutput("oneshot_ignored", bitOut, old);
        checkOutput("oneshot_done_hold", done, 1);

        // Reset mid-capture: pointers lost, stored bits kept, valid in IDLE writes nothing.
        applyStimulus(randX(), randY(), 0, 0, 1, 0, 0);
        for (int i = 0; i < 20; i++) applyStimulus(randX(), randY(), 1, 1'($urandom % 2), 0, 0, 0);
        doReset();
        for (int i = 0; i < 8; i++) applyStimulus(randX(), randY(), 1, 1'($urandom % 2), 0, 0, 0);

        // Full sweep of the bitmap against the model.
        for (int yy = 0; yy < V; yy++)
            for (int xx = 0; xx < H; xx++)
                applyStimulus(xx, yy, 0, 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
